// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port with a single
// outstanding transaction, starvation protection for fetch and fetch flush.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_aclk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_ma_req,
    input  logic        i_ma_we,
    input  logic [31:0] i_ma_addr,
    input  logic [31:0] i_ma_wdata,
    input  logic [3:0]  i_ma_be,
    output logic        o_ma_gnt,
    output logic        o_ma_rvalid,
    output logic [31:0] o_ma_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_err_spurious
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_MA = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          drop_q, drop_d;
    logic          err_q, err_d;
    logic          any_req_s;
    logic          fetch_sel_s;

    assign any_req_s   = i_if_req | i_ma_req;
    // Data wins ties unless fetch has lost STARVE_LIMIT times in a row.
    assign fetch_sel_s = i_if_req & (~i_ma_req | (starve_q == STARVE_MAX));

    // State register with synchronous reset
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
        end
    end

    // Arbitration, next-state logic and memory/response steering
    always_comb begin
        state_d        = state_q;
        starve_d       = starve_q;
        drop_d         = drop_q;
        err_d          = err_q;
        o_if_gnt       = 1'b0;
        o_if_rvalid    = 1'b0;
        o_if_rdata     = 32'h0000_0000;
        o_ma_gnt       = 1'b0;
        o_ma_rvalid    = 1'b0;
        o_ma_rdata     = 32'h0000_0000;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr     = 32'h0000_0000;
        o_mem_wdata    = 32'h0000_0000;
        o_mem_be       = 4'b0000;
        o_busy         = 1'b0;
        o_err_spurious = err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_mem_rvalid) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (any_req_s) begin
                    o_mem_req = 1'b1;
                    if (fetch_sel_s) begin
                        o_mem_addr = i_if_addr;
                        o_mem_be   = 4'b1111;
                        if (i_mem_ready) begin
                            o_if_gnt = 1'b1;
                            state_d  = ST_BUSY_IF;
                            starve_d = '0;
                            drop_d   = i_if_flush;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        o_mem_we    = i_ma_we;
                        o_mem_addr  = i_ma_addr;
                        o_mem_wdata = i_ma_wdata;
                        o_mem_be    = i_ma_be;
                        if (i_mem_ready) begin
                            o_ma_gnt = 1'b1;
                            state_d  = ST_BUSY_MA;
                            if (i_if_req && (starve_q != STARVE_MAX)) begin
                                starve_d = starve_q + CW'(1);
                            end else begin
                                starve_d = starve_q;
                            end
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_IF: begin
                o_busy = 1'b1;
                if (i_mem_rvalid) begin
                    // A flush in the response cycle also suppresses the data.
                    o_if_rvalid = ~drop_q & ~i_if_flush;
                    o_if_rdata  = (~drop_q & ~i_if_flush) ? i_mem_rdata : 32'h0000_0000;
                    drop_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else if (i_if_flush) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            ST_BUSY_MA: begin
                o_busy = 1'b1;
                if (i_mem_rvalid) begin
                    o_ma_rvalid = 1'b1;
                    o_ma_rdata  = i_mem_rdata;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_BUSY_MA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are forced quiet for the whole time reset is held.
        if (i_reset) begin
            o_if_gnt       = 1'b0;
            o_if_rvalid    = 1'b0;
            o_if_rdata     = 32'h0000_0000;
            o_ma_gnt       = 1'b0;
            o_ma_rvalid    = 1'b0;
            o_ma_rdata     = 32'h0000_0000;
            o_mem_req      = 1'b0;
            o_mem_we       = 1'b0;
            o_mem_addr     = 32'h0000_0000;
            o_mem_wdata    = 32'h0000_0000;
            o_mem_be       = 4'b0000;
            o_busy         = 1'b0;
            o_err_spurious = 1'b0;
        end else begin
            o_busy = o_busy;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive fetch losses before fetch wins priority.
REQ-002 i_aclk  in  1  system clock; all state updates on rising edge.
REQ-003 i_reset  in  1  reset, synchronous, active-high.
REQ-004 i_if_req  in  1  fetch request; held high with stable address until o_if_gnt.
REQ-005 i_if_addr  in  32  fetch word address.
REQ-006 i_if_flush  in  1  branch redirect; discards any outstanding fetch response.
REQ-007 o_if_gnt  out  1  fetch request accepted by memory this cycle.
REQ-008 o_if_rvalid  out  1  fetch data valid; o_if_rdata  out  32  fetch data.
REQ-009 i_ma_req  in  1  data request; held high with stable fields until o_ma_gnt.
REQ-010 i_ma_we  in  1  write; i_ma_addr  in  32; i_ma_wdata  in  32; i_ma_be  in  4  byte enables.
REQ-011 o_ma_gnt  out  1  data request accepted; o_ma_rvalid  out  1  read data or write ack; o_ma_rdata  out  32.
REQ-012 o_mem_req  out  1; o_mem_we  out  1; o_mem_addr  out  32; o_mem_wdata  out  32; o_mem_be  out  4  shared memory port.
REQ-013 i_mem_ready  in  1  memory accepts o_mem_req this cycle.
REQ-014 i_mem_rvalid  in  1  response for the single outstanding request; i_mem_rdata  in  32.
REQ-015 o_busy  out  1  transaction outstanding; o_err_spurious  out  1  sticky, i_mem_rvalid seen in IDLE.

Function
REQ-016 States SHALL be IDLE, BUSY_IF, BUSY_MA; at most one memory transaction outstanding.
REQ-017 In IDLE, o_mem_req SHALL equal i_if_req | i_ma_req; address/control SHALL be driven combinationally from the selected requester.
REQ-018 Selection: data requester wins when both request, unless starve counter == STARVE_LIMIT, then fetch wins.
REQ-019 Starve counter (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating, on each data grant while i_if_req high; SHALL clear on any fetch grant.
REQ-020 Grant = IDLE & selected & i_mem_ready; o_x_gnt SHALL be high exactly one cycle per accepted request; next state BUSY_IF or BUSY_MA.
REQ-021 IDLE with i_mem_ready low: no grant, state held, selection re-evaluated next cycle.
REQ-022 In BUSY_*, o_mem_req SHALL be 0 and o_if_gnt/o_ma_gnt SHALL be 0.
REQ-023 In BUSY_x with i_mem_rvalid: o_x_rvalid = 1 and o_x_rdata = i_mem_rdata same cycle (zero added latency); next state IDLE.
REQ-024 New grant earliest the cycle after the response cycle (minimum 2 cycles between grants).
REQ-025 Fetch flush: i_if_flush in BUSY_IF, or in IDLE coincident with o_if_gnt, SHALL set a drop flag; the matching response SHALL complete the transaction with o_if_rvalid = 0; flag clears on that response.
REQ-026 i_if_flush in the same cycle as the BUSY_IF response SHALL suppress o_if_rvalid.
REQ-027 i_if_flush SHALL NOT affect data transactions or the starve counter.
REQ-028 i_mem_rvalid in IDLE SHALL be ignored (no rvalid out) and SHALL set o_err_spurious.
REQ-029 o_if_rdata/o_ma_rdata SHALL be 0 when corresponding rvalid is 0.
REQ-030 o_busy SHALL be 1 in BUSY_IF and BUSY_MA.

Reset
REQ-031 i_reset high at clock edge: state IDLE, starve counter 0, drop flag 0, o_err_spurious 0; applies mid-transaction, abandoning it.
REQ-032 While i_reset is high, all outputs SHALL be 0 (including o_mem_req).
REQ-033 A response arriving after reset-abandoned transaction SHALL be treated per REQ-028.

Verification
REQ-034 Both req high, ready=1, counter 0 -> o_ma_gnt=1, o_if_gnt=0, state BUSY_MA, counter 1.
REQ-035 Fetch req held continuously while data req won 4 times (STARVE_LIMIT=4) -> 5th arbitration grants fetch, counter returns 0.
REQ-036 Fetch granted addr 0x100, flush next cycle, rvalid rdata 0xDEADBEEF 3 cycles later -> o_if_rvalid stays 0, state IDLE, next request granted following cycle.
REQ-037 Data write granted, i_mem_ready low 2 cycles beforehand -> no grant until ready=1; on rvalid, o_ma_rvalid=1 single cycle.
REQ-038 Reset asserted in BUSY_MA, then rvalid after reset release -> o_ma_rvalid=0, o_err_spurious=1.
REQ-039 Back-to-back: response cycle with both req high -> no grant that cycle, grant next cycle, o_mem_req low during BUSY.
